// File: rtl/fetch_sequencer.sv
// Program-counter and fetch sequencer: next-PC selection, imem handshake, halt/resume,
// precise trap with EPC capture, and a retired-instruction counter.
module fetch_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter int          BYTE_ADDR = 0,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC   = 32'h0000_0100,
  parameter int          TRAP_HALT = 0,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               branch_taken,
  input  logic [15:0]        branch_off,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               jump_reg,
  input  logic [ADDR_W-1:0]  jr_target,
  input  logic               invalid_inst,
  input  logic               trap_clr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               commit,
  output logic               halted,
  output logic               trap_flag,
  output logic [ADDR_W-1:0]  epc,
  output logic [COUNT_W-1:0] retired
);

  localparam int SH = (BYTE_ADDR != 0) ? 2 : 0;
  localparam int JB = 26 + SH;
  localparam logic [ADDR_W-1:0] STEP = (BYTE_ADDR != 0) ? ADDR_W'(4) : ADDR_W'(1);
  // Bits of link_addr kept by a direct jump; zero when the jump field covers the whole PC.
  localparam logic [ADDR_W-1:0] HI_MASK =
    (ADDR_W > JB) ? ~((ADDR_W'(1) << JB) - ADDR_W'(1)) : '0;
  localparam logic [ADDR_W-1:0] RST_PC_V  = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] TRAP_PC_V = TRAP_PC[ADDR_W-1:0];

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic               trap_q, trap_d;
  logic [COUNT_W-1:0] retired_q, retired_d;

  logic [ADDR_W-1:0]  link_s;
  logic [31:0]        off32_s;
  logic [ADDR_W-1:0]  branch_tgt_s;
  logic [27:0]        jfield_s;
  logic [ADDR_W-1:0]  jump_tgt_s;
  logic               commit_s;
  logic               imem_req_s;
  logic               halted_s;

  // Redirect target arithmetic, all modulo 2^ADDR_W.
  always_comb begin
    link_s       = pc_q + STEP;
    off32_s      = {{16{branch_off[15]}}, branch_off};
    branch_tgt_s = link_s + (ADDR_W'(off32_s) << SH);
    if (BYTE_ADDR != 0) begin
      jfield_s = {jump_index, 2'b00};
    end else begin
      jfield_s = {2'b00, jump_index};
    end
    jump_tgt_s = (link_s & HI_MASK) | (ADDR_W'(jfield_s) & ~HI_MASK);
  end

  // Next-state, next-PC, trap and counter logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    trap_d     = trap_q;
    retired_d  = retired_q;
    commit_s   = 1'b0;
    imem_req_s = 1'b0;
    halted_s   = 1'b0;
    if (trap_clr) begin
      trap_d = 1'b0;
    end else begin
      trap_d = trap_q;
    end
    case (state_q)
      FETCH: begin
        imem_req_s = 1'b1;
        if (halt_req) begin
          state_d = HALTED;
        end else if (imem_valid && !stall && !rst) begin
          commit_s = 1'b1;
          if (invalid_inst) begin
            // A trap overrides a same-cycle clear and is not counted as retired.
            pc_d   = TRAP_PC_V;
            epc_d  = pc_q;
            trap_d = 1'b1;
            if (TRAP_HALT != 0) begin
              state_d = HALTED;
            end else begin
              state_d = FETCH;
            end
          end else begin
            retired_d = retired_q + COUNT_W'(1);
            if (branch_taken) begin
              pc_d = branch_tgt_s;
            end else if (jump) begin
              pc_d = jump_tgt_s;
            end else if (jump_reg) begin
              pc_d = jr_target;
            end else begin
              pc_d = link_s;
            end
          end
        end else begin
          pc_d = pc_q;
        end
      end
      HALTED: begin
        halted_s = 1'b1;
        if (resume && !halt_req) begin
          state_d = FETCH;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RST_PC_V;
      epc_q     <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req  = imem_req_s;
  assign pc        = pc_q;
  assign link_addr = link_s;
  assign commit    = commit_s;
  assign halted    = halted_s;
  assign trap_flag = trap_q;
  assign epc       = epc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table on the default build, plus hand sequences
// for byte addressing with halt-on-trap and for a narrow PC/counter build.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v, st, hr, rs, br, jp, jr, inv, clr;
  logic [15:0] off;
  logic [25:0] ji;
  logic [31:0] jt;

  always #5 clk = ~clk;

  logic        a_req, a_commit, a_halt, a_trap;
  logic [31:0] a_pc, a_link, a_epc, a_ret;
  logic        b_req, b_commit, b_halt, b_trap;
  logic [31:0] b_pc, b_link, b_epc, b_ret;
  logic        c_req, c_commit, c_halt, c_trap;
  logic [15:0] c_pc, c_link, c_epc;
  logic [3:0]  c_ret;

  fetch_sequencer dut_a (
    .clk(clk), .rst(rst), .imem_valid(v), .stall(st), .halt_req(hr), .resume(rs),
    .branch_taken(br), .branch_off(off), .jump(jp), .jump_index(ji), .jump_reg(jr),
    .jr_target(jt), .invalid_inst(inv), .trap_clr(clr), .imem_req(a_req), .pc(a_pc),
    .link_addr(a_link), .commit(a_commit), .halted(a_halt), .trap_flag(a_trap),
    .epc(a_epc), .retired(a_ret));

  fetch_sequencer #(.BYTE_ADDR(1), .TRAP_HALT(1)) dut_b (
    .clk(clk), .rst(rst), .imem_valid(v), .stall(st), .halt_req(hr), .resume(rs),
    .branch_taken(br), .branch_off(off), .jump(jp), .jump_index(ji), .jump_reg(jr),
    .jr_target(jt), .invalid_inst(inv), .trap_clr(clr), .imem_req(b_req), .pc(b_pc),
    .link_addr(b_link), .commit(b_commit), .halted(b_halt), .trap_flag(b_trap),
    .epc(b_epc), .retired(b_ret));

  fetch_sequencer #(.ADDR_W(16), .COUNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .imem_valid(v), .stall(st), .halt_req(hr), .resume(rs),
    .branch_taken(br), .branch_off(off), .jump(jp), .jump_index(ji), .jump_reg(jr),
    .jr_target(jt[15:0]), .invalid_inst(inv), .trap_clr(clr), .imem_req(c_req), .pc(c_pc),
    .link_addr(c_link), .commit(c_commit), .halted(c_halt), .trap_flag(c_trap),
    .epc(c_epc), .retired(c_ret));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    v = 1'b0; st = 1'b0; hr = 1'b0; rs = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0;
    inv = 1'b0; clr = 1'b0; off = 16'h0000; ji = 26'h0; jt = 32'h0;
  endtask

  typedef struct {
    logic        v, st, hr, rs, br;
    logic [15:0] off;
    logic        jp;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] jt;
    logic        inv, clr;
    logic        e_commit;
    logic [31:0] e_pc, e_ret;
    logic        e_halt, e_trap;
    logic [31:0] e_epc;
  } vec_t;

  function automatic vec_t mk(input logic v_, st_, hr_, rs_, br_, input logic [15:0] off_,
                              input logic jp_, input logic [25:0] ji_, input logic jr_,
                              input logic [31:0] jt_, input logic inv_, clr_, ec,
                              input logic [31:0] ep, er, input logic eh, et,
                              input logic [31:0] ee);
    vec_t r;
    r.v = v_; r.st = st_; r.hr = hr_; r.rs = rs_; r.br = br_; r.off = off_;
    r.jp = jp_; r.ji = ji_; r.jr = jr_; r.jt = jt_; r.inv = inv_; r.clr = clr_;
    r.e_commit = ec; r.e_pc = ep; r.e_ret = er; r.e_halt = eh; r.e_trap = et; r.e_epc = ee;
    return r;
  endfunction

  vec_t vt[$];

  initial begin
    logic [31:0] prev_pc;
    logic        prev_halt;
    clear_in();
    // Vector table for the default build: v st hr rs br off jp ji jr jt inv clr | commit pc ret halt trap epc
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,0,32'h0,0,0, 1, 32'(i+1), 32'(i+1), 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,1,32'h10,0,0,      1, 32'h10, 32'd6, 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,1,16'hFFFE,1,26'h40,1,32'h99,0,0,  1, 32'h0F, 32'd7, 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,16'h0,1,26'h40,1,32'h99,0,0,     1, 32'h40, 32'd8, 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,1,32'h99,0,0,      1, 32'h99, 32'd9, 0,0,32'h0));
    vt.push_back(mk(0,0,0,0,0,16'h0,0,26'h0,0,32'h0,0,0,       0, 32'h99, 32'd9, 0,0,32'h0));
    vt.push_back(mk(0,0,0,0,1,16'h5,0,26'h0,0,32'h0,0,0,       0, 32'h99, 32'd9, 0,0,32'h0));
    vt.push_back(mk(0,0,0,0,0,16'h0,0,26'h0,1,32'h5,0,0,       0, 32'h99, 32'd9, 0,0,32'h0));
    vt.push_back(mk(1,1,0,0,1,16'h5,0,26'h0,0,32'h0,0,0,       0, 32'h99, 32'd9, 0,0,32'h0));
    vt.push_back(mk(1,1,0,0,1,16'h5,0,26'h0,0,32'h0,0,0,       0, 32'h99, 32'd9, 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,0,32'h0,0,0,       1, 32'h9A, 32'd10, 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,1,32'h22,0,0,      1, 32'h22, 32'd11, 0,0,32'h0));
    vt.push_back(mk(1,0,0,0,1,16'h5,0,26'h0,0,32'h0,1,0,       1, 32'h100, 32'd11, 0,1,32'h22));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,0,32'h0,0,0,       1, 32'h101, 32'd12, 0,1,32'h22));
    vt.push_back(mk(0,0,0,0,0,16'h0,0,26'h0,0,32'h0,0,1,       0, 32'h101, 32'd12, 0,0,32'h22));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,0,32'h0,1,1,       1, 32'h100, 32'd12, 0,1,32'h101));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,1,32'h7,0,0,       1, 32'h7, 32'd13, 0,1,32'h101));
    vt.push_back(mk(1,0,1,0,0,16'h0,0,26'h0,0,32'h0,0,0,       0, 32'h7, 32'd13, 1,1,32'h101));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,1,32'h99,0,0,      0, 32'h7, 32'd13, 1,1,32'h101));
    vt.push_back(mk(1,0,1,1,0,16'h0,0,26'h0,0,32'h0,0,0,       0, 32'h7, 32'd13, 1,1,32'h101));
    vt.push_back(mk(0,0,0,1,0,16'h0,0,26'h0,0,32'h0,0,0,       0, 32'h7, 32'd13, 0,1,32'h101));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,0,32'h0,0,0,       1, 32'h8, 32'd14, 0,1,32'h101));
    vt.push_back(mk(1,0,0,0,1,16'h3,0,26'h0,0,32'h0,0,0,       1, 32'hC, 32'd15, 0,1,32'h101));
    vt.push_back(mk(1,0,0,0,0,16'h0,0,26'h0,1,32'hF000_0010,0,0, 1, 32'hF000_0010, 32'd16, 0,1,32'h101));
    vt.push_back(mk(1,0,0,0,0,16'h0,1,26'h3,0,32'h0,0,0,       1, 32'hF000_0003, 32'd17, 0,1,32'h101));

    // Reset values while rst is held high.
    tick(); tick();
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_ret", a_ret, 32'h0);
    chk("rst_req", {31'b0, a_req}, 32'h1);
    chk("rst_commit", {31'b0, a_commit}, 32'h0);
    chk("rst_halt", {31'b0, a_halt}, 32'h0);
    chk("rst_trap", {31'b0, a_trap}, 32'h0);
    chk("rst_epc", a_epc, 32'h0);
    rst = 1'b0;

    prev_pc = 32'h0;
    prev_halt = 1'b0;
    foreach (vt[i]) begin
      v = vt[i].v; st = vt[i].st; hr = vt[i].hr; rs = vt[i].rs; br = vt[i].br;
      off = vt[i].off; jp = vt[i].jp; ji = vt[i].ji; jr = vt[i].jr; jt = vt[i].jt;
      inv = vt[i].inv; clr = vt[i].clr;
      #1;
      chk($sformatf("v%0d_commit", i), {31'b0, a_commit}, {31'b0, vt[i].e_commit});
      chk($sformatf("v%0d_link", i), a_link, prev_pc + 32'd1);
      chk($sformatf("v%0d_req", i), {31'b0, a_req}, {31'b0, ~prev_halt});
      tick();
      chk($sformatf("v%0d_pc", i), a_pc, vt[i].e_pc);
      chk($sformatf("v%0d_ret", i), a_ret, vt[i].e_ret);
      chk($sformatf("v%0d_halt", i), {31'b0, a_halt}, {31'b0, vt[i].e_halt});
      chk($sformatf("v%0d_trap", i), {31'b0, a_trap}, {31'b0, vt[i].e_trap});
      chk($sformatf("v%0d_epc", i), a_epc, vt[i].e_epc);
      prev_pc = vt[i].e_pc;
      prev_halt = vt[i].e_halt;
    end

    // Asynchronous reset mid-cycle discards a pending redirect.
    clear_in();
    v = 1'b1; jr = 1'b1; jt = 32'h55;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pc", a_pc, 32'h0);
    chk("arst_ret", a_ret, 32'h0);
    chk("arst_commit", {31'b0, a_commit}, 32'h0);
    tick();
    chk("arst_hold_pc", a_pc, 32'h0);
    clear_in();
    tick();
    rst = 1'b0;

    // Sequential fetch on all builds; byte-addressed build steps by 4.
    for (int i = 0; i < 5; i++) begin
      v = 1'b1;
      tick();
      chk($sformatf("b_seq%0d_pc", i), b_pc, 32'(4 * (i + 1)));
      chk($sformatf("b_seq%0d_link", i), b_link, 32'(4 * (i + 2)));
    end
    chk("c_seq_pc", {16'h0, c_pc}, 32'h5);
    inv = 1'b1;
    #1;
    chk("b_trap_commit", {31'b0, b_commit}, 32'h1);
    tick();
    inv = 1'b0;
    chk("b_trap_pc", b_pc, 32'h100);
    chk("b_trap_epc", b_epc, 32'h14);
    chk("b_trap_flag", {31'b0, b_trap}, 32'h1);
    chk("b_trap_halt", {31'b0, b_halt}, 32'h1);
    chk("b_trap_req", {31'b0, b_req}, 32'h0);
    chk("b_trap_ret", b_ret, 32'd5);
    for (int i = 0; i < 12; i++) tick();
    chk("c_ret_wrap", {28'h0, c_ret}, 32'd1);
    chk("c_pc_after", {16'h0, c_pc}, 32'h10C);
    chk("b_halt_pc", b_pc, 32'h100);
    chk("b_halt_ret", b_ret, 32'd5);
    jr = 1'b1; jt = 32'h0000_FFFF;
    tick();
    jr = 1'b0;
    chk("c_pc_top", {16'h0, c_pc}, 32'h0000_FFFF);
    tick();
    chk("c_pc_wrap", {16'h0, c_pc}, 32'h0);
    chk("c_ret3", {28'h0, c_ret}, 32'd3);

    // Byte-addressed redirects after resuming the halted build.
    clear_in();
    rs = 1'b1;
    tick();
    rs = 1'b0;
    chk("b_resume", {31'b0, b_halt}, 32'h0);
    v = 1'b1; br = 1'b1; off = 16'hFFFF;
    tick();
    br = 1'b0;
    chk("b_branch", b_pc, 32'h100);
    jr = 1'b1; jt = 32'h103;
    tick();
    jr = 1'b0;
    chk("b_jr_unaligned", b_pc, 32'h103);
    jp = 1'b1; ji = 26'h40;
    tick();
    jp = 1'b0;
    chk("b_jump", b_pc, 32'h100);
    chk("b_ret", b_ret, 32'd8);
    clear_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
